// File: rtl/mips_pkg.sv
// mips_pkg
// Shared definitions for the multi-cycle memory sequencer: FSM state
// encoding, bus error cause codes and the default request timeout.
package mips_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_DECODE = 3'd2,
      ST_DATA   = 3'd3,
      ST_COMMIT = 3'd4,
      ST_ERROR  = 3'd5
   } seq_state_t;

   localparam logic [1:0] ERR_NONE        = 2'b00;
   localparam logic [1:0] ERR_FETCH_TO    = 2'b01;
   localparam logic [1:0] ERR_DATA_TO     = 2'b10;
   localparam logic [1:0] ERR_RW_CONFLICT = 2'b11;

   localparam int DEFAULT_TIMEOUT = 255;

endpackage

// File: rtl/mod_mem_sequencer_if.sv
// mod_mem_sequencer_if
// Single-ported memory bus shared by instruction fetch and data access.
//   mem_req   : request valid (sequencer -> memory)
//   mem_we    : 1 = write
//   mem_addr  : address
//   mem_wdata : write data
//   mem_rdata : read data (memory -> sequencer)
//   mem_ack   : completion, one cycle per request
interface mod_mem_sequencer_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_ack;

   modport master (
      output mem_req, mem_we, mem_addr, mem_wdata,
      input  mem_rdata, mem_ack
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_wdata,
      output mem_rdata, mem_ack
   );
endinterface

// File: rtl/mod_wait_timer.sv
// mod_wait_timer
// Counts request cycles that ended without an ack. Flags expiry in the
// TIMEOUT-th such cycle so the caller can leave the request state on
// that same edge.
//   clk, reset : clock, asynchronous active-low reset
//   i_clear    : hold counter at zero (no request outstanding)
//   i_enable   : current cycle is a request cycle without ack
//   o_count    : number of unacked request cycles so far
//   o_expired  : this unacked cycle is the TIMEOUT-th one
module mod_wait_timer #(
   parameter int TO_W    = 8,
   parameter int TIMEOUT = 255
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            i_clear,
   input  logic            i_enable,
   output logic [TO_W-1:0] o_count,
   output logic            o_expired
);

   logic [TO_W-1:0] r_count;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         r_count <= '0;
      else if (i_clear)
         r_count <= '0;
      else if (i_enable)
         r_count <= r_count + TO_W'(1);
   end

   // r_count holds the unacked cycles already completed, so TIMEOUT-1
   // means the current unacked cycle is the TIMEOUT-th.
   assign o_expired = i_enable && (r_count == TO_W'(TIMEOUT - 1));
   assign o_count   = r_count;

endmodule

// File: rtl/mod_mem_sequencer.sv
// mod_mem_sequencer
// Multi-cycle memory sequencer between the MIPS datapath and a single
// ported memory. Fetches the instruction, performs the optional load or
// store, then pulses commit so the core updates PC and register file.
//   clk, reset           : clock, asynchronous active-low reset
//   pc                   : current PC, stable from FETCH through COMMIT
//   core_mem_read/write  : decoded load/store request, sampled in DECODE
//   core_data_address    : load/store address, sampled in DECODE
//   core_wdata           : store data, sampled in DECODE
//   instruction, data    : registered fetched instruction / load data
//   commit               : one-cycle retire pulse
//   mem                  : memory bus (master side)
//   bus_error, err_cause : sticky error flag and its cause
//   instr_count          : retired-instruction counter
//
// state  | meaning
// IDLE   | after reset, fetch starts next cycle
// FETCH  | instruction read request at pc, wait for ack
// DECODE | core decodes latched instruction, no request
// DATA   | load/store request from captured registers, wait for ack
// COMMIT | commit pulse, retire counter increments
// ERROR  | terminal until reset, no requests, no commits
module mod_mem_sequencer
   import mips_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = DEFAULT_TIMEOUT,
   parameter int TO_W    = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] pc,
   input  logic              core_mem_read,
   input  logic              core_mem_write,
   input  logic [ADDR_W-1:0] core_data_address,
   input  logic [DATA_W-1:0] core_wdata,
   output logic [DATA_W-1:0] instruction,
   output logic [DATA_W-1:0] data,
   output logic              commit,
   mod_mem_sequencer_if.master mem,
   output logic              bus_error,
   output logic [1:0]        err_cause,
   output logic [31:0]       instr_count
);

   seq_state_t        r_state;
   seq_state_t        w_state_nxt;
   logic [1:0]        r_err_cause;
   logic [1:0]        w_err_nxt;
   logic [DATA_W-1:0] r_instruction;
   logic [DATA_W-1:0] r_data;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic              r_we;
   logic [31:0]       r_instr_count;

   logic              w_mem_req;
   logic              w_mem_we;
   logic [ADDR_W-1:0] w_mem_addr;
   logic [DATA_W-1:0] w_mem_wdata;
   logic              w_commit;
   logic              w_ack;
   logic              w_expired;
   logic [TO_W-1:0]   w_wait_count;
   logic              w_rw_conflict;
   logic              w_rw_any;

   // ack only means something while a request is outstanding
   assign w_ack         = w_mem_req && mem.mem_ack;
   assign w_rw_conflict = core_mem_read && core_mem_write;
   assign w_rw_any      = core_mem_read || core_mem_write;

   mod_wait_timer #(
      .TO_W    (TO_W),
      .TIMEOUT (TIMEOUT)
   ) u_wait_timer (
      .clk       (clk),
      .reset     (reset),
      .i_clear   (!w_mem_req),
      .i_enable  (w_mem_req && !mem.mem_ack),
      .o_count   (w_wait_count),
      .o_expired (w_expired)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         r_state <= ST_IDLE;
      else
         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_err_nxt   = r_err_cause;
      w_mem_req   = 1'b0;
      w_mem_we    = 1'b0;
      w_mem_addr  = '0;
      w_mem_wdata = '0;
      w_commit    = 1'b0;
      unique case (r_state)
         ST_IDLE: w_state_nxt = ST_FETCH;
         ST_FETCH: begin
            w_mem_req  = 1'b1;
            w_mem_addr = pc;
            if (mem.mem_ack) begin
               w_state_nxt = ST_DECODE;
            end else if (w_expired) begin
               w_state_nxt = ST_ERROR;
               w_err_nxt   = ERR_FETCH_TO;
            end
         end
         ST_DECODE: begin
            if (w_rw_conflict) begin
               w_state_nxt = ST_ERROR;
               w_err_nxt   = ERR_RW_CONFLICT;
            end else if (w_rw_any) begin
               w_state_nxt = ST_DATA;
            end else begin
               w_state_nxt = ST_COMMIT;
            end
         end
         ST_DATA: begin
            w_mem_req   = 1'b1;
            w_mem_we    = r_we;
            w_mem_addr  = r_addr;
            w_mem_wdata = r_wdata;
            if (mem.mem_ack) begin
               w_state_nxt = ST_COMMIT;
            end else if (w_expired) begin
               w_state_nxt = ST_ERROR;
               w_err_nxt   = ERR_DATA_TO;
            end
         end
         ST_COMMIT: begin
            w_commit    = 1'b1;
            w_state_nxt = ST_FETCH;
         end
         ST_ERROR: w_state_nxt = ST_ERROR;
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_err_cause   <= ERR_NONE;
         r_instruction <= '0;
         r_data        <= '0;
         r_addr        <= '0;
         r_wdata       <= '0;
         r_we          <= 1'b0;
         r_instr_count <= '0;
      end else begin
         r_err_cause <= w_err_nxt;
         if (r_state == ST_FETCH && w_ack)
            r_instruction <= mem.mem_rdata;
         if (r_state == ST_DECODE && w_rw_any && !w_rw_conflict) begin
            r_addr  <= core_data_address;
            r_wdata <= core_wdata;
            r_we    <= core_mem_write;
         end
         if (r_state == ST_DATA && w_ack && !r_we)
            r_data <= mem.mem_rdata;
         if (w_commit)
            r_instr_count <= r_instr_count + 32'd1;
      end
   end

   assign mem.mem_req   = w_mem_req;
   assign mem.mem_we    = w_mem_we;
   assign mem.mem_addr  = w_mem_addr;
   assign mem.mem_wdata = w_mem_wdata;

   assign instruction = r_instruction;
   assign data        = r_data;
   assign commit      = w_commit;
   assign bus_error   = (r_state == ST_ERROR);
   assign err_cause   = r_err_cause;
   assign instr_count = r_instr_count;

endmodule

// File: tb/tb_mod_mem_sequencer.sv
module tb_mod_mem_sequencer;

   logic        clk;
   logic        reset;
   logic [31:0] pc;
   logic        core_mem_read;
   logic        core_mem_write;
   logic [31:0] core_data_address;
   logic [31:0] core_wdata;
   logic [31:0] instruction;
   logic [31:0] data;
   logic        commit;
   logic        bus_error;
   logic [1:0]  err_cause;
   logic [31:0] instr_count;

   int n_vec;
   int n_err;
   int n_commit;
   int n_berr_low;

   mod_mem_sequencer_if #(.ADDR_W(32), .DATA_W(32)) u_mem_if ();

   mod_mem_sequencer #(
      .ADDR_W  (32),
      .DATA_W  (32),
      .TIMEOUT (4),
      .TO_W    (8)
   ) u_dut (
      .clk               (clk),
      .reset             (reset),
      .pc                (pc),
      .core_mem_read     (core_mem_read),
      .core_mem_write    (core_mem_write),
      .core_data_address (core_data_address),
      .core_wdata        (core_wdata),
      .instruction       (instruction),
      .data              (data),
      .commit            (commit),
      .mem               (u_mem_if),
      .bus_error         (bus_error),
      .err_cause         (err_cause),
      .instr_count       (instr_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      reset = 1'b0;
      pc = 32'h0;
      core_mem_read = 1'b0;
      core_mem_write = 1'b0;
      core_data_address = 32'h0;
      core_wdata = 32'h0;
      u_mem_if.mem_ack = 1'b0;
      u_mem_if.mem_rdata = 32'h0;

      // reset state
      tick();
      tick();
      chk("rst_req", {31'b0, u_mem_if.mem_req}, 32'd0);
      chk("rst_commit", {31'b0, commit}, 32'd0);
      chk("rst_berr", {31'b0, bus_error}, 32'd0);
      chk("rst_cause", {30'b0, err_cause}, 32'd0);
      chk("rst_icnt", instr_count, 32'd0);
      chk("rst_instr", instruction, 32'd0);
      chk("rst_data", data, 32'd0);
      chk("rst_addr", u_mem_if.mem_addr, 32'd0);
      reset = 1'b1;

      // zero-wait add at pc 0: FETCH, DECODE, COMMIT
      tick();
      chk("add_fetch_req", {31'b0, u_mem_if.mem_req}, 32'd1);
      chk("add_fetch_addr", u_mem_if.mem_addr, 32'h0);
      chk("add_fetch_we", {31'b0, u_mem_if.mem_we}, 32'd0);
      u_mem_if.mem_ack = 1'b1;
      u_mem_if.mem_rdata = 32'h0022_0820;
      tick();
      u_mem_if.mem_ack = 1'b0;
      chk("add_instr", instruction, 32'h0022_0820);
      chk("add_dec_req", {31'b0, u_mem_if.mem_req}, 32'd0);
      chk("add_dec_commit", {31'b0, commit}, 32'd0);
      tick();
      chk("add_commit", {31'b0, commit}, 32'd1);
      chk("add_commit_req", {31'b0, u_mem_if.mem_req}, 32'd0);
      pc = 32'h4;
      tick();
      chk("add_icnt", instr_count, 32'd1);
      chk("add_commit_off", {31'b0, commit}, 32'd0);
      chk("add_refetch_req", {31'b0, u_mem_if.mem_req}, 32'd1);

      // load from 0x10 with two wait states
      chk("ld_fetch_addr", u_mem_if.mem_addr, 32'h4);
      u_mem_if.mem_ack = 1'b1;
      u_mem_if.mem_rdata = 32'h8C02_0010;
      tick();
      u_mem_if.mem_ack = 1'b0;
      core_mem_read = 1'b1;
      core_data_address = 32'h10;
      tick();
      core_mem_read = 1'b0;
      core_data_address = 32'hFFFF_FFF0;
      for (int i = 0; i < 3; i++) begin
         chk("ld_data_req", {31'b0, u_mem_if.mem_req}, 32'd1);
         chk("ld_data_addr", u_mem_if.mem_addr, 32'h10);
         chk("ld_data_we", {31'b0, u_mem_if.mem_we}, 32'd0);
         if (i == 2) begin
            u_mem_if.mem_ack = 1'b1;
            u_mem_if.mem_rdata = 32'hDEAD_BEEF;
         end
         tick();
      end
      u_mem_if.mem_ack = 1'b0;
      chk("ld_data", data, 32'hDEAD_BEEF);
      chk("ld_commit", {31'b0, commit}, 32'd1);
      chk("ld_commit_we", {31'b0, u_mem_if.mem_we}, 32'd0);
      pc = 32'h8;
      tick();
      chk("ld_icnt", instr_count, 32'd2);

      // store 0x1234_5678 to 0x20
      chk("st_fetch_addr", u_mem_if.mem_addr, 32'h8);
      chk("st_fetch_we", {31'b0, u_mem_if.mem_we}, 32'd0);
      u_mem_if.mem_ack = 1'b1;
      u_mem_if.mem_rdata = 32'hAC02_0020;
      tick();
      u_mem_if.mem_ack = 1'b0;
      core_mem_write = 1'b1;
      core_data_address = 32'h20;
      core_wdata = 32'h1234_5678;
      chk("st_dec_we", {31'b0, u_mem_if.mem_we}, 32'd0);
      tick();
      core_mem_write = 1'b0;
      core_wdata = 32'h0;
      chk("st_data_we", {31'b0, u_mem_if.mem_we}, 32'd1);
      chk("st_data_addr", u_mem_if.mem_addr, 32'h20);
      chk("st_data_wdata", u_mem_if.mem_wdata, 32'h1234_5678);
      u_mem_if.mem_ack = 1'b1;
      u_mem_if.mem_rdata = 32'hBAD0_BAD0;
      tick();
      u_mem_if.mem_ack = 1'b0;
      chk("st_data_kept", data, 32'hDEAD_BEEF);
      chk("st_commit", {31'b0, commit}, 32'd1);
      chk("st_commit_we", {31'b0, u_mem_if.mem_we}, 32'd0);
      pc = 32'hC;
      tick();
      chk("st_commit_off", {31'b0, commit}, 32'd0);
      chk("st_icnt", instr_count, 32'd3);

      // fetch timeout with TIMEOUT=4: now in request cycle 1
      tick();
      tick();
      tick();
      chk("to_req_c4", {31'b0, u_mem_if.mem_req}, 32'd1);
      chk("to_berr_c4", {31'b0, bus_error}, 32'd0);
      tick();
      chk("to_berr", {31'b0, bus_error}, 32'd1);
      chk("to_cause", {30'b0, err_cause}, 32'd1);
      chk("to_req_off", {31'b0, u_mem_if.mem_req}, 32'd0);
      n_commit = 0;
      n_berr_low = 0;
      for (int i = 0; i < 50; i++) begin
         u_mem_if.mem_ack = i[0];
         core_mem_read = i[1];
         core_mem_write = i[2];
         tick();
         if (commit) n_commit++;
         if (!bus_error || u_mem_if.mem_req) n_berr_low++;
      end
      u_mem_if.mem_ack = 1'b0;
      core_mem_read = 1'b0;
      core_mem_write = 1'b0;
      chk("to_no_commit", n_commit, 32'd0);
      chk("to_sticky", n_berr_low, 32'd0);
      chk("to_cause_held", {30'b0, err_cause}, 32'd1);
      chk("to_icnt_held", instr_count, 32'd3);
      reset = 1'b0;
      #1;
      chk("to_rst_berr", {31'b0, bus_error}, 32'd0);
      chk("to_rst_cause", {30'b0, err_cause}, 32'd0);
      chk("to_rst_icnt", instr_count, 32'd0);
      tick();
      reset = 1'b1;

      // ack in the TIMEOUT-th request cycle is accepted, then R/W conflict
      pc = 32'h40;
      tick();
      tick();
      tick();
      tick();
      chk("late_req", {31'b0, u_mem_if.mem_req}, 32'd1);
      u_mem_if.mem_ack = 1'b1;
      u_mem_if.mem_rdata = 32'h0000_0001;
      tick();
      u_mem_if.mem_ack = 1'b0;
      chk("late_berr", {31'b0, bus_error}, 32'd0);
      chk("late_instr", instruction, 32'h0000_0001);
      core_mem_read = 1'b1;
      core_mem_write = 1'b1;
      tick();
      core_mem_read = 1'b0;
      core_mem_write = 1'b0;
      chk("rw_berr", {31'b0, bus_error}, 32'd1);
      chk("rw_cause", {30'b0, err_cause}, 32'd3);
      chk("rw_commit", {31'b0, commit}, 32'd0);

      // data timeout
      reset = 1'b0;
      tick();
      reset = 1'b1;
      tick();
      u_mem_if.mem_ack = 1'b1;
      u_mem_if.mem_rdata = 32'h8C00_0000;
      tick();
      u_mem_if.mem_ack = 1'b0;
      core_mem_read = 1'b1;
      core_data_address = 32'h30;
      tick();
      core_mem_read = 1'b0;
      tick();
      tick();
      tick();
      chk("dto_req_c4", {31'b0, u_mem_if.mem_req}, 32'd1);
      tick();
      chk("dto_berr", {31'b0, bus_error}, 32'd1);
      chk("dto_cause", {30'b0, err_cause}, 32'd2);

      // reset mid-DATA, ack a cycle later must be discarded
      reset = 1'b0;
      tick();
      reset = 1'b1;
      tick();
      u_mem_if.mem_ack = 1'b1;
      u_mem_if.mem_rdata = 32'h8C00_0044;
      tick();
      u_mem_if.mem_ack = 1'b0;
      core_mem_read = 1'b1;
      core_data_address = 32'h30;
      tick();
      core_mem_read = 1'b0;
      chk("mid_data_req", {31'b0, u_mem_if.mem_req}, 32'd1);
      reset = 1'b0;
      #1;
      chk("mid_rst_req", {31'b0, u_mem_if.mem_req}, 32'd0);
      tick();
      u_mem_if.mem_ack = 1'b1;
      u_mem_if.mem_rdata = 32'h5555_5555;
      tick();
      chk("mid_rst_data", data, 32'h0);
      chk("mid_rst_instr", instruction, 32'h0);
      reset = 1'b1;
      tick();
      u_mem_if.mem_ack = 1'b0;
      chk("mid_idle_data", data, 32'h0);
      chk("mid_idle_instr", instruction, 32'h0);
      chk("mid_restart_req", {31'b0, u_mem_if.mem_req}, 32'd1);
      chk("mid_restart_we", {31'b0, u_mem_if.mem_we}, 32'd0);
      u_mem_if.mem_ack = 1'b1;
      u_mem_if.mem_rdata = 32'h0000_0042;
      tick();
      u_mem_if.mem_ack = 1'b0;
      chk("mid_restart_instr", instruction, 32'h0000_0042);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/mod_mem_sequencer.md
# mod_mem_sequencer

Multi-cycle memory sequencer for the MIPS core. It shares one external memory port between instruction fetch and data load/store. It holds the fetched instruction and loaded data in registers. It issues a one-cycle `commit` pulse that enables the core's PC and register-file update, and it sits between the processor datapath and the single-ported memory.

## Interface
Parameters:
- `ADDR_W`, 32, memory address width
- `DATA_W`, 32, memory data width
- `TIMEOUT`, 255, maximum request cycles without ack before error (1..2^TO_W-1)
- `TO_W`, 8, wait-counter width

Ports:
- `clk`  in  1  single clock, all state on rising edge
- `reset`  in  1  asynchronous, active-low reset
- `pc`  in  ADDR_W  current PC from core
- `core_mem_read`  in  1  decoded load request (valid in DECODE)
- `core_mem_write`  in  1  decoded store request (valid in DECODE)
- `core_data_address`  in  ADDR_W  load/store address
- `core_wdata`  in  DATA_W  store data
- `instruction`  out  DATA_W  registered fetched instruction
- `data`  out  DATA_W  registered load data
- `commit`  out  1  one-cycle pulse: core updates PC/regfile
- `mem_req`  out  1  memory request
- `mem_we`  out  1  1 = write
- `mem_addr`  out  ADDR_W  memory address
- `mem_wdata`  out  DATA_W  memory write data
- `mem_rdata`  in  DATA_W  memory read data
- `mem_ack`  in  1  memory completion
- `bus_error`  out  1  sticky error flag
- `err_cause`  out  2  01 fetch timeout, 10 data timeout, 11 read+write conflict
- `instr_count`  out  32  retired-instruction counter

## Operation
- States: IDLE, FETCH, DECODE, DATA, COMMIT, ERROR.
- IDLE always moves to FETCH on the next cycle.
- FETCH:
  - Drives `mem_req`=1, `mem_we`=0, `mem_addr`=`pc`.
  - On `mem_ack`: latch `mem_rdata` into `instruction`, then go to DECODE.
- DECODE:
  - No request.
  - Samples the core's decode of the latched instruction.
  - `core_mem_read` and `core_mem_write` both high: go to ERROR, cause 11.
  - Either one high: go to DATA, capturing address, write data and direction into internal registers.
  - Neither high: go to COMMIT.
- DATA:
  - Drives `mem_req`=1, `mem_we` = captured write, `mem_addr`/`mem_wdata` from the captured registers.
  - On `mem_ack`: if a read, latch `mem_rdata` into `data` (a write leaves `data` unchanged), then go to COMMIT.
- COMMIT:
  - `commit`=1 for exactly this cycle.
  - `instr_count` += 1, wrapping modulo 2^32.
  - Then go to FETCH.
- Timeout:
  - The wait counter clears on entry to FETCH or DATA and increments each request cycle without ack.
  - If no ack arrives in `TIMEOUT` consecutive request cycles, go to ERROR with cause 01 (FETCH) or 10 (DATA).
  - An ack in the TIMEOUT-th cycle is accepted.
- ERROR is terminal until reset:
  - `bus_error`=1 and `err_cause` holds its value.
  - `mem_req`=0, and `commit` never fires.
- Ignored inputs:
  - `mem_ack` while `mem_req`=0 is ignored.
  - `core_*` inputs outside DECODE are ignored.

## Timing
- Reset asserted (asynchronous) forces:
  - state IDLE
  - `instruction`, `data`, `instr_count` = 0
  - `commit`, `mem_req`, `mem_we`, `bus_error` = 0
  - `err_cause` = 00
  - `mem_addr`, `mem_wdata` = 0
- Reset asserted mid-request drops `mem_req` immediately, and any pending ack is discarded.
- `mem_req`, `mem_we`, `mem_addr` and `mem_wdata` are decoded from registered state only, so they are glitch-free. They are held stable from request start until the ack cycle inclusive.
- A zero-wait memory may return ack in the first request cycle.
- With zero-wait memory:
  - Non-memory instruction: 3 cycles (FETCH, DECODE, COMMIT).
  - Load/store: 4 cycles.
  - Each wait state adds one cycle.
- `instruction` is updated on the edge ending the FETCH ack cycle and is stable through COMMIT.
- `data` is valid from DATA exit through COMMIT.
- `pc` must be stable from FETCH through COMMIT; the core updates it on the COMMIT edge only.

## Structure
- Shared package `mips_pkg` holds:
  - state encoding enum
  - `err_cause` codes (ERR_NONE, ERR_FETCH_TO, ERR_DATA_TO, ERR_RW_CONFLICT)
  - default `TIMEOUT`
- One sub-module, `mod_wait_timer`:
  - Inputs: clear, enable.
  - Outputs: TO_W-bit counter, `expired` flag.
  - Instantiated once, shared by FETCH and DATA.
- The FSM, capture registers and retire counter stay in `mod_mem_sequencer`.

## Test plan
- Zero-wait memory, `pc`=0x0000_0000, add instruction: `mem_req` high 1 cycle, `commit` on cycle 3, `instr_count`=1, then a new FETCH.
- Load, address 0x10 with 2 wait states, rdata 0xDEAD_BEEF: DATA holds req/addr stable 3 cycles, `data`=0xDEAD_BEEF at COMMIT, `mem_we`=0 throughout.
- Store, address 0x20, wdata 0x1234_5678: `mem_we`=1 only in DATA, `data` unchanged, `commit` once.
- Fetch with no ack, TIMEOUT=4: ERROR after 4 request cycles, `err_cause`=01, `bus_error` sticky, no `commit` for 50 cycles, reset clears it.
- DECODE with `core_mem_read`=`core_mem_write`=1: ERROR, `err_cause`=11. Separately, reset asserted mid-DATA with ack arriving a cycle later: no latch, restart from IDLE.
